// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM bank between NB_REQ load/store ports.
// Drives the bank pins directly and returns a one-cycle-latency response.
module tcdm_bank_rr_arbiter #(
   parameter int NB_REQ         = 16,
   parameter int ADDR_MEM_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                      Clk,
   input  logic                                      Reset,
   input  logic                                      Bank_En_I,
   input  logic [NB_REQ-1:0]                         Req_I,
   input  logic [NB_REQ-1:0]                         Wen_I,
   input  logic [NB_REQ-1:0][ADDR_MEM_WIDTH-1:0]     Addr_I,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]         Wdata_I,
   output logic [NB_REQ-1:0]                         Gnt_O,
   output logic [NB_REQ-1:0]                         R_Valid_O,
   output logic [DATA_WIDTH-1:0]                     R_Data_O,
   output logic                                      Bank_CSN_O,
   output logic                                      Bank_WEN_O,
   output logic [ADDR_MEM_WIDTH-1:0]                 Bank_A_O,
   output logic [DATA_WIDTH-1:0]                     Bank_D_O,
   input  logic [DATA_WIDTH-1:0]                     Bank_Q_I,
   input  logic                                      Cnt_Clr_I,
   output logic [CNT_WIDTH-1:0]                      Conflict_Cnt_O
);

   localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

   logic [PTR_W-1:0]          ptr_q;
   logic [PTR_W-1:0]          win_idx;
   logic                      win_vld;
   logic                      grant_en;
   logic [NB_REQ-1:0]         rsp_q;
   logic [ADDR_MEM_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0]     d_q;
   logic [CNT_WIDTH-1:0]      cnt_q;
   logic                      multi_req;

   // Scan from the priority pointer upward, wrapping at NB_REQ-1.
   always_comb begin
      int j;
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      for (int i = 0; i < NB_REQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NB_REQ) j = j - NB_REQ;
         if (!win_vld && Req_I[j]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'(j);
         end
      end
   end

   // Reset gates the grant so the bank stays deselected while held in reset.
   assign grant_en   = Reset & Bank_En_I & win_vld;
   assign Gnt_O      = grant_en ? (NB_REQ'(1) << win_idx) : '0;
   assign Bank_CSN_O = ~grant_en;
   assign Bank_WEN_O = grant_en ? Wen_I[win_idx] : 1'b1;
   assign Bank_A_O   = grant_en ? Addr_I[win_idx] : a_q;
   assign Bank_D_O   = grant_en ? Wdata_I[win_idx] : d_q;

   assign R_Valid_O      = rsp_q;
   assign R_Data_O       = Bank_Q_I;
   assign Conflict_Cnt_O = cnt_q;
   assign multi_req      = |(Req_I & (Req_I - NB_REQ'(1)));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ptr_q <= '0;
         rsp_q <= '0;
         a_q   <= '0;
         d_q   <= '0;
      end else begin
         rsp_q <= Gnt_O;
         if (grant_en) begin
            ptr_q <= (win_idx == PTR_W'(NB_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            a_q   <= Bank_A_O;
            d_q   <= Bank_D_O;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else if (Cnt_Clr_I) begin
         cnt_q <= '0;
      end else if (Bank_En_I && multi_req && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Directed bench for tcdm_bank_rr_arbiter with a behavioural 1024x32 bank model.
module tb_tcdm_bank_rr_arbiter;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Bank_En_I;
   logic [15:0]       Req_I;
   logic [15:0]       Wen_I;
   logic [15:0][9:0]  Addr_I;
   logic [15:0][31:0] Wdata_I;
   logic [15:0]       Gnt_O;
   logic [15:0]       R_Valid_O;
   logic [31:0]       R_Data_O;
   logic              Bank_CSN_O;
   logic              Bank_WEN_O;
   logic [9:0]        Bank_A_O;
   logic [31:0]       Bank_D_O;
   logic [31:0]       Bank_Q_I;
   logic              Cnt_Clr_I;
   logic [15:0]       Conflict_Cnt_O;

   int total = 0;
   int bad   = 0;

   logic        pre_en;
   logic [9:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [0:1023];

   always #5 Clk = ~Clk;

   tcdm_bank_rr_arbiter #(
      .NB_REQ(16), .ADDR_MEM_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(16)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Bank_En_I(Bank_En_I), .Req_I(Req_I),
      .Wen_I(Wen_I), .Addr_I(Addr_I), .Wdata_I(Wdata_I), .Gnt_O(Gnt_O),
      .R_Valid_O(R_Valid_O), .R_Data_O(R_Data_O), .Bank_CSN_O(Bank_CSN_O),
      .Bank_WEN_O(Bank_WEN_O), .Bank_A_O(Bank_A_O), .Bank_D_O(Bank_D_O),
      .Bank_Q_I(Bank_Q_I), .Cnt_Clr_I(Cnt_Clr_I), .Conflict_Cnt_O(Conflict_Cnt_O)
   );

   // Bank model: synchronous SRAM, read data one cycle after CSN=0.
   always @(posedge Clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (!Bank_CSN_O) begin
         if (!Bank_WEN_O) mem[Bank_A_O] <= Bank_D_O;
         else             Bank_Q_I <= mem[Bank_A_O];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic wen, input logic [9:0] a, input logic [31:0] d);
      Wen_I[i]   = wen;
      Addr_I[i]  = a;
      Wdata_I[i] = d;
   endtask

   initial begin
      Reset = 1'b0; Bank_En_I = 1'b1; Req_I = 16'hFFFF; Wen_I = '1;
      Addr_I = '0; Wdata_I = '0; Cnt_Clr_I = 1'b0;
      pre_en = 1'b1; pre_addr = 10'h3A5; pre_data = 32'hDEADBEEF;

      // Reset state with all requests pending
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_gnt", 32'(Gnt_O), 32'h0);
      chk("rst_csn", 32'(Bank_CSN_O), 32'h1);
      chk("rst_rvalid", 32'(R_Valid_O), 32'h0);
      chk("rst_cnt", 32'(Conflict_Cnt_O), 32'h0);
      @(negedge Clk); Reset = 1'b1; pre_en = 1'b0; Req_I = '0;

      // Single load from requester 2
      @(negedge Clk); Req_I = 16'h0004; set_req(2, 1'b1, 10'h3A5, 32'h0); #1;
      chk("t1_gnt", 32'(Gnt_O), 32'h0004);
      chk("t1_csn", 32'(Bank_CSN_O), 32'h0);
      chk("t1_wen", 32'(Bank_WEN_O), 32'h1);
      chk("t1_addr", 32'(Bank_A_O), 32'h3A5);
      @(negedge Clk); Req_I = '0; #1;
      chk("t1_rvalid", 32'(R_Valid_O), 32'h0004);
      chk("t1_rdata", R_Data_O, 32'hDEADBEEF);
      chk("t1_idle_gnt", 32'(Gnt_O), 32'h0);
      chk("t1_idle_csn", 32'(Bank_CSN_O), 32'h1);
      chk("t1_idle_wen", 32'(Bank_WEN_O), 32'h1);
      chk("t1_addr_hold", 32'(Bank_A_O), 32'h3A5);

      // Store by 3 then load by 5 (ptr=3)
      @(negedge Clk); Req_I = 16'h0008; set_req(3, 1'b0, 10'h010, 32'h12345678); #1;
      chk("t4_st_gnt", 32'(Gnt_O), 32'h0008);
      chk("t4_st_wen", 32'(Bank_WEN_O), 32'h0);
      chk("t4_st_a", 32'(Bank_A_O), 32'h010);
      chk("t4_st_d", Bank_D_O, 32'h12345678);
      @(negedge Clk); Req_I = 16'h0020; set_req(5, 1'b1, 10'h010, 32'h0); #1;
      chk("t4_st_rvalid", 32'(R_Valid_O), 32'h0008);
      chk("t4_ld_gnt", 32'(Gnt_O), 32'h0020);
      chk("t4_ld_wen", 32'(Bank_WEN_O), 32'h1);
      @(negedge Clk); Req_I = '0; #1;
      chk("t4_ld_rvalid", 32'(R_Valid_O), 32'h0020);
      chk("t4_ld_rdata", R_Data_O, 32'h12345678);

      // Wrap: ptr=6 -> grant 14 -> ptr=15
      @(negedge Clk); Req_I = 16'h4000; #1;
      chk("t3_gnt14", 32'(Gnt_O), 32'h4000);
      @(negedge Clk); Req_I = 16'h8001; #1;
      chk("t3_gnt15", 32'(Gnt_O), 32'h8000);
      @(negedge Clk); Req_I = 16'h0001; #1;
      chk("t3_gnt0", 32'(Gnt_O), 32'h0001);
      @(negedge Clk); Req_I = 16'h0003; #1;
      chk("t3_ptr1", 32'(Gnt_O), 32'h0002);

      // ptr=2, two conflicts counted so far
      @(negedge Clk); Req_I = 16'h0003; #1;
      chk("t5_pre_gnt", 32'(Gnt_O), 32'h0001);
      chk("t3_cnt", 32'(Conflict_Cnt_O), 32'd2);
      @(negedge Clk); Bank_En_I = 1'b0; Req_I = 16'hFFFF; #1;
      chk("t5_gnt", 32'(Gnt_O), 32'h0);
      chk("t5_csn", 32'(Bank_CSN_O), 32'h1);
      chk("t5_inflight", 32'(R_Valid_O), 32'h0001);
      chk("t5_cnt", 32'(Conflict_Cnt_O), 32'd3);
      @(negedge Clk); #1;
      chk("t5_cnt_frozen", 32'(Conflict_Cnt_O), 32'd3);
      chk("t5_rvalid_off", 32'(R_Valid_O), 32'h0);
      @(negedge Clk); Bank_En_I = 1'b1; Req_I = 16'hFFFE; #1;
      chk("t5_ptr_held", 32'(Gnt_O), 32'h0002);

      // Saturation: counter preset near all-ones, ptr=2
      @(negedge Clk); Bank_En_I = 1'b0; Req_I = '0;
      force dut.cnt_q = 16'hFFFE;
      #1 release dut.cnt_q;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk); Bank_En_I = 1'b1; Req_I = 16'hFFFF; #1;
         chk($sformatf("t5_sat_gnt%0d", k), 32'(Gnt_O), 32'h0004 << k);
         chk($sformatf("t5_sat_cnt%0d", k), 32'(Conflict_Cnt_O), (k == 0) ? 32'hFFFE : 32'hFFFF);
      end
      @(negedge Clk); Cnt_Clr_I = 1'b1; #1;
      chk("t5_sat_hold", 32'(Conflict_Cnt_O), 32'hFFFF);
      chk("t5_clr_gnt", 32'(Gnt_O), 32'h0020);
      @(negedge Clk); Cnt_Clr_I = 1'b0; Req_I = '0; #1;
      chk("t5_clr", 32'(Conflict_Cnt_O), 32'h0);

      // Reset the cycle after a grant (ptr=6)
      @(negedge Clk); Req_I = 16'h0100; #1;
      chk("t6_gnt", 32'(Gnt_O), 32'h0100);
      @(negedge Clk); Req_I = '0; #1;
      chk("t6_rvalid_pre", 32'(R_Valid_O), 32'h0100);
      Reset = 1'b0; Req_I = 16'hFFFF; #1;
      chk("t6_rvalid_drop", 32'(R_Valid_O), 32'h0);
      chk("t6_rst_gnt", 32'(Gnt_O), 32'h0);
      chk("t6_rst_csn", 32'(Bank_CSN_O), 32'h1);
      @(negedge Clk); Reset = 1'b1; Req_I = 16'h8002; #1;
      chk("t6_first", 32'(Gnt_O), 32'h0002);

      // All requests from reset, each dropping after its grant
      @(negedge Clk); Reset = 1'b0; Req_I = 16'hFFFF;
      @(negedge Clk); Reset = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge Clk);
         Req_I = 16'hFFFF << k; #1;
         chk($sformatf("t2_gnt%0d", k), 32'(Gnt_O), 32'h1 << k);
         chk($sformatf("t2_cnt%0d", k), 32'(Conflict_Cnt_O), 32'(k));
      end
      @(negedge Clk); Req_I = 16'hFFFF; #1;
      chk("t2_cnt_final", 32'(Conflict_Cnt_O), 32'd15);
      chk("t2_gnt_wrap", 32'(Gnt_O), 32'h0001);
      chk("t2_rvalid15", 32'(R_Valid_O), 32'h8000);

      @(negedge Clk); Req_I = '0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
